// File: rtl/axi_ad9364_tx_sched.sv
// Transmit sample scheduler for the AD9364 dac_* port: slot cadence generation,
// two-source valid/ready arbitration, zero-fill and underflow accounting.
module axi_ad9364_tx_sched #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned START_DELAY = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      r1_mode,
  input  logic [1:0]                src_sel,
  input  logic                      src0_valid,
  output logic                      src0_ready,
  input  logic [4*DATA_WIDTH-1:0]   src0_data,
  input  logic                      src1_valid,
  output logic                      src1_ready,
  input  logic [4*DATA_WIDTH-1:0]   src1_data,
  output logic                      dac_valid,
  output logic [DATA_WIDTH-1:0]     dac_data_i1,
  output logic [DATA_WIDTH-1:0]     dac_data_q1,
  output logic [DATA_WIDTH-1:0]     dac_data_i2,
  output logic [DATA_WIDTH-1:0]     dac_data_q2,
  output logic                      dac_r1_mode,
  output logic                      underflow,
  input  logic                      underflow_clr,
  output logic [15:0]               underflow_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  localparam logic [7:0] DLY_LOAD = 8'(START_DELAY - 1);

  state_t                    r_state, w_state_nxt;
  logic [7:0]                r_dly, w_dly_nxt;
  logic [1:0]                r_slot, w_slot_nxt;
  logic                      r_r1, w_r1_nxt;
  logic                      r_dac_valid;
  logic [4*DATA_WIDTH-1:0]   r_dac_data;
  logic                      r_uf;
  logic [15:0]               r_uf_cnt;
  logic                      w_slot, w_take, w_uf_evt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
      r_slot  <= '0;
      r_r1    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_slot  <= w_slot_nxt;
      r_r1    <= w_r1_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_slot_nxt  = r_slot;
    w_r1_nxt    = r_r1;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_START;
          w_dly_nxt   = DLY_LOAD;
          w_r1_nxt    = r1_mode;
        end
      end
      S_START: begin
        if (!enable)
          w_state_nxt = S_IDLE;
        else if (r_dly == '0)
          w_state_nxt = S_RUN;
        else
          w_dly_nxt = r_dly - 8'd1;
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_slot_nxt  = '0;
        end else if (r_slot == (r_r1 ? 2'd1 : 2'd3)) begin
          w_slot_nxt = '0;
        end else begin
          w_slot_nxt = r_slot + 2'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Readys follow the slot even when enable drops in it; only the output side is suppressed.
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    w_slot     = (r_state == S_RUN) && (r_slot == '0);
    if (w_slot) begin
      case (src_sel)
        2'b00: src0_ready = src0_valid;
        2'b01: src1_ready = src1_valid;
        2'b10: begin
          src0_ready = src0_valid;
          src1_ready = src1_valid & ~src0_valid;
        end
        default: ;
      endcase
    end
    w_take   = w_slot & enable;
    w_uf_evt = w_take && (src_sel != 2'b11) && !src0_ready && !src1_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dac_valid <= 1'b0;
      r_dac_data  <= '0;
    end else begin
      r_dac_valid <= w_take;
      if (w_take)
        r_dac_data <= src0_ready ? src0_data : (src1_ready ? src1_data : '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else if (underflow_clr) begin
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else if (w_uf_evt) begin
      r_uf <= 1'b1;
      if (r_uf_cnt != '1)
        r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign dac_valid     = r_dac_valid;
  assign dac_data_i1   = r_dac_data[0*DATA_WIDTH +: DATA_WIDTH];
  assign dac_data_q1   = r_dac_data[1*DATA_WIDTH +: DATA_WIDTH];
  assign dac_data_i2   = r_dac_data[2*DATA_WIDTH +: DATA_WIDTH];
  assign dac_data_q2   = r_dac_data[3*DATA_WIDTH +: DATA_WIDTH];
  assign dac_r1_mode   = r_r1;
  assign underflow     = r_uf;
  assign underflow_cnt = r_uf_cnt;
  assign busy          = (r_state != S_IDLE);

endmodule
